// File: rtl/hdlverifier_capture_pkg.sv
// Shared definitions for the windowed capture buffer: state encoding, window depth
// and the pre-trigger count saturation rule.
package hdlverifier_capture_pkg;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StPrefill  = 3'd1;
  localparam logic [2:0] StWaitTrig = 3'd2;
  localparam logic [2:0] StPosttrig = 3'd3;
  localparam logic [2:0] StReadout  = 3'd4;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Pre-trigger count may not exceed the window minus the trigger sample itself.
  function automatic int unsigned sat_position(input int unsigned pos,
                                               input int unsigned depth);
    return (pos > depth - 1) ? depth - 1 : pos;
  endfunction

endpackage

// File: rtl/hdlverifier_capture_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
module hdlverifier_capture_ram #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/hdlverifier_capture_buffer.sv
// Windowed capture buffer: circular pre/post-trigger capture into RAM, then ordered
// readout of the full window over valid/ready with a prefetching output register.
module hdlverifier_capture_buffer
  import hdlverifier_capture_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  trigger,
  input  logic                  arm,
  input  logic [ADDR_WIDTH-1:0] trigger_position,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  triggered,
  output logic                  capture_done
);

  localparam int unsigned Depth = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] MaxIdx = ADDR_WIDTH'(Depth - 1);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, cnt_q, post_q, p_q, trig_addr_q, raddr_q;
  logic [ADDR_WIDTH:0]   rcnt_q;
  logic                  triggered_q, done_q, ram_vld_q, ram_last_q;
  logic [DATA_WIDTH-1:0] rd_data_q, ram_rdata;
  logic                  rd_valid_q, rd_last_q;

  logic                  wr_en, trig_hit, out_ready, move, issue, last_beat;
  logic [ADDR_WIDTH-1:0] p_sat, trig_addr_cur;

  assign p_sat = ADDR_WIDTH'(sat_position(32'(trigger_position), Depth));
  assign wr_en = clk_enable &&
                 (state_q == StPrefill || state_q == StWaitTrig || state_q == StPosttrig);
  assign trig_hit = clk_enable && trigger && (state_q == StWaitTrig);
  assign trig_addr_cur = trig_hit ? wptr_q : trig_addr_q;

  // Prefetch: refill the RAM output stage whenever it is empty or drains this cycle.
  assign out_ready = !rd_valid_q || rd_ready;
  assign move      = ram_vld_q && out_ready;
  assign issue     = (state_q == StReadout) && !rcnt_q[ADDR_WIDTH] && (!ram_vld_q || move);
  assign last_beat = rd_valid_q && rd_ready && rd_last_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (arm) state_d = (p_sat == '0) ? StWaitTrig : StPrefill;
      StPrefill:  if (clk_enable && cnt_q == p_q - 1'b1) state_d = StWaitTrig;
      StWaitTrig: if (trig_hit) state_d = (p_q == MaxIdx) ? StReadout : StPosttrig;
      StPosttrig: if (clk_enable && post_q == ADDR_WIDTH'(1)) state_d = StReadout;
      StReadout:  if (last_beat) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      cnt_q       <= '0;
      post_q      <= '0;
      p_q         <= '0;
      trig_addr_q <= '0;
      raddr_q     <= '0;
      rcnt_q      <= '0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      ram_vld_q   <= 1'b0;
      ram_last_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (state_q == StPrefill && clk_enable) cnt_q <= cnt_q + 1'b1;
      if (state_q == StPosttrig && clk_enable) post_q <= post_q - 1'b1;
      if (state_q == StIdle && arm) begin
        p_q         <= p_sat;
        wptr_q      <= '0;
        cnt_q       <= '0;
        triggered_q <= 1'b0;
      end
      if (trig_hit) begin
        trig_addr_q <= wptr_q;
        triggered_q <= 1'b1;
        post_q      <= MaxIdx - p_q;
      end
      if (state_d == StReadout && state_q != StReadout) begin
        done_q  <= 1'b1;
        raddr_q <= trig_addr_cur - p_q;
        rcnt_q  <= '0;
      end
      if (last_beat) done_q <= 1'b0;

      if (issue) begin
        raddr_q    <= raddr_q + 1'b1;
        rcnt_q     <= rcnt_q + 1'b1;
        ram_last_q <= (rcnt_q[ADDR_WIDTH-1:0] == MaxIdx);
        ram_vld_q  <= 1'b1;
      end else if (move) begin
        ram_vld_q  <= 1'b0;
      end

      if (move) begin
        rd_data_q  <= ram_rdata;
        rd_valid_q <= 1'b1;
        rd_last_q  <= ram_last_q;
      end else if (rd_ready) begin
        rd_valid_q <= 1'b0;
        rd_last_q  <= 1'b0;
      end
    end
  end

  hdlverifier_capture_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wptr_q),
    .wdata(data),
    .re   (issue),
    .raddr(raddr_q),
    .rdata(ram_rdata)
  );

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign rd_last      = rd_last_q;
  assign busy         = (state_q != StIdle);
  assign triggered    = triggered_q;
  assign capture_done = done_q;

endmodule
